// File: rtl/vec_cmd_issuer.sv
// vec_cmd_issuer: command FIFO + issue sequencer in front of the vector accelerator.
// Ports: cmd_* host push, acc_* accelerator issue/done/read, resp_* read results, busy/done_count status.
module vec_cmd_issuer #(
  parameter int els_p        = 12,
  parameter int vlen_p       = 4,
  parameter int vdw_p        = 8,
  parameter int fifo_depth_p = 4,
  localparam int aw = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int dw = vlen_p * vdw_p
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             cmd_v_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [aw-1:0]    cmd_addrA_i,
  input  logic [aw-1:0]    cmd_addrB_i,
  input  logic [aw-1:0]    cmd_addrD_i,
  input  logic [vdw_p-1:0] cmd_scalar_i,
  input  logic [dw-1:0]    cmd_w_data_i,
  output logic [3:0]       acc_op_o,
  output logic [aw-1:0]    acc_addrA_o,
  output logic [aw-1:0]    acc_addrB_o,
  output logic [aw-1:0]    acc_addrD_o,
  output logic [vdw_p-1:0] acc_scalar_o,
  output logic [dw-1:0]    acc_w_data_o,
  output logic             acc_v_o,
  input  logic             acc_ready_i,
  input  logic             acc_done_i,
  input  logic             acc_v_i,
  input  logic [dw-1:0]    acc_r_data_i,
  output logic             acc_yumi_o,
  output logic             resp_v_o,
  input  logic             resp_ready_i,
  output logic [dw-1:0]    resp_data_o,
  output logic             busy_o,
  output logic [15:0]      done_count_o
);

  localparam int pw = (fifo_depth_p > 1) ? $clog2(fifo_depth_p) : 1;
  localparam logic [3:0] OP_READ = 4'b1000;

  typedef struct packed {
    logic [3:0]       op;
    logic [aw-1:0]    a;
    logic [aw-1:0]    b;
    logic [aw-1:0]    d;
    logic [vdw_p-1:0] scalar;
    logic [dw-1:0]    wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_e;

  cmd_t          mem [fifo_depth_p];
  cmd_t          in_cmd;
  cmd_t          head;
  logic [pw-1:0] wr_ptr;
  logic [pw-1:0] rd_ptr;
  logic [pw:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_e        state;
  state_e        state_n;
  logic          rd_q;
  logic          cnt_inc;
  logic          resp_ld;
  logic [dw-1:0] resp_q;
  logic [15:0]   done_q;

  assign in_cmd = '{cmd_op_i, cmd_addrA_i, cmd_addrB_i,
                    cmd_addrD_i, cmd_scalar_i, cmd_w_data_i};
  assign head   = mem[rd_ptr];
  assign full   = (count == (pw+1)'(fifo_depth_p));
  assign empty  = (count == '0);
  assign push   = cmd_v_i & ~full;

  assign cmd_ready_o  = ~full;
  assign acc_op_o     = head.op;
  assign acc_addrA_o  = head.a;
  assign acc_addrB_o  = head.b;
  assign acc_addrD_o  = head.d;
  assign acc_scalar_o = head.scalar;
  assign acc_w_data_o = head.wdata;
  assign resp_data_o  = resp_q;
  assign done_count_o = done_q;
  assign busy_o       = (state != IDLE) | ~empty;

  // Storage is cleared so the head fields read as zero during reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < fifo_depth_p; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_cmd;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    acc_v_o    = 1'b0;
    acc_yumi_o = 1'b0;
    resp_v_o   = 1'b0;
    cnt_inc    = 1'b0;
    resp_ld    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_n = ISSUE;
      end
      ISSUE: begin
        acc_v_o = 1'b1;
        if (acc_ready_i) begin
          pop     = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        acc_yumi_o = rd_q;
        if (rd_q) begin
          if (acc_done_i & acc_v_i) begin
            resp_ld = 1'b1;
            cnt_inc = 1'b1;
            state_n = RESP;
          end
        end else if (acc_done_i) begin
          cnt_inc = 1'b1;
          state_n = IDLE;
        end
      end
      RESP: begin
        resp_v_o = 1'b1;
        if (resp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= IDLE;
      rd_q   <= 1'b0;
      resp_q <= '0;
      done_q <= '0;
    end else begin
      state <= state_n;
      if (pop)     rd_q   <= (head.op == OP_READ);
      if (resp_ld) resp_q <= acc_r_data_i;
      if (cnt_inc) done_q <= done_q + 16'd1;
    end
  end

endmodule

// File: doc/vec_cmd_issuer.md
# vec_cmd_issuer

Command queue and issue sequencer sitting directly upstream of the vector/matrix accelerator `top`. It buffers host commands in a small FIFO and issues them one at a time over the accelerator's `v_i`/`ready_o` handshake. It waits for `done_o` before issuing the next command, captures read results, and presents them on a valid/ready response port, so the host never sequences the accelerator cycle by cycle.

## Interface
- `els_p`, 12: vectors in the accelerator regfile; `aw = BSG_SAFE_CLOG2(els_p)`.
- `vlen_p`, 4: elements per vector.
- `vdw_p`, 8: bits per element; `dw = vlen_p*vdw_p`.
- `fifo_depth_p`, 4: command FIFO entries; power of two, ≥2.
- `clk_i` in 1: clock. Single clock domain.
- `reset_n_i` in 1: reset, asynchronous and active-low.
- `cmd_v_i` in 1 / `cmd_ready_o` out 1: command handshake; the command is accepted when both are high at a rising edge.
- `cmd_op_i` in 4, `cmd_addrA_i` / `cmd_addrB_i` / `cmd_addrD_i` in aw, `cmd_scalar_i` in vdw_p, `cmd_w_data_i` in dw: command fields.
- `acc_op_o` out 4, `acc_addrA_o` / `acc_addrB_o` / `acc_addrD_o` out aw, `acc_scalar_o` out vdw_p, `acc_w_data_o` out dw: fields of the FIFO head entry.
- `acc_v_o` out 1 / `acc_ready_i` in 1: issue handshake to the accelerator.
- `acc_done_i` in 1, `acc_v_i` in 1, `acc_r_data_i` in dw: completion status and read data from the accelerator.
- `acc_yumi_o` out 1: read-data acknowledge to the accelerator.
- `resp_v_o` out 1 / `resp_ready_i` in 1, `resp_data_o` out dw: read-result handshake.
- `busy_o` out 1: FSM not in IDLE or FIFO not empty.
- `done_count_o` out 16: count of completed commands; wraps at 2^16.

## Operation
- FIFO: registered, in-order, `fifo_depth_p` entries.
  - `cmd_ready_o = !full`, with no dependence on a same-cycle pop.
  - No bypass: a command pushed while the FIFO is empty becomes the head on the next cycle.
- Op classes: `4'b1000` is READ, `4'b1001` WRITE, `4'b1111` MMUL, `4'b00xx`/`4'b01xx` ALU. All ops, including unlisted codes, are forwarded unchanged. Only READ produces a response.
- FSM states are IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is not empty, go to ISSUE.
  - ISSUE: `acc_v_o = 1` and `acc_*_o` carry the head fields.
    - On `acc_ready_i`: pop the head, latch its op class, go to WAIT.
    - Otherwise hold, with the fields stable.
  - WAIT: `acc_yumi_o = 1` if and only if the latched op is READ.
    - Non-READ: on `acc_done_i`, increment `done_count_o` and go to IDLE.
    - READ: on `acc_done_i & acc_v_i`, load `acc_r_data_i` into the response register, increment `done_count_o`, and go to RESP.
  - RESP: `resp_v_o = 1`. On `resp_ready_i`, go to IDLE.
- `acc_done_i` and `acc_v_i` are ignored outside WAIT.
- In any state other than ISSUE, `acc_v_o = 0` and `acc_*_o` are don't-care; the implementation drives the head fields.
- `resp_data_o` holds its last value outside RESP.
- Reset (asynchronous, `reset_n_i` low), including mid-operation:
  - FIFO is emptied and the FSM goes to IDLE.
  - `done_count_o` and the response register are cleared.
  - Outputs while in reset: `cmd_ready_o = 1`, all other outputs 0.
  - The accelerator is reset by the same net; no in-flight command is replayed.

## Timing
- Push at edge N into an empty, idle block: FIFO non-empty in cycle N+1, ISSUE in cycle N+2 with `acc_v_o` high.
- Issue to WAIT: one edge after `acc_ready_i` is seen high.
- WAIT to IDLE: one edge after done. The next issue follows at the earliest 2 cycles later, i.e. one IDLE bubble.
- READ path:
  - `resp_v_o` rises the cycle after the qualifying done.
  - `resp_data_o` is stable while `resp_v_o` is high.
  - No new issue occurs until the response handshake completes.
- FIFO full with the FSM stalled: `cmd_ready_o` stays low and an offered command is not captured.
- Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- `done_count_o` updates on the same edge as the WAIT exit; `0xFFFF + 1` wraps to 0.

## Test plan
- Reset: hold `reset_n_i` low for 3 cycles → `cmd_ready_o = 1`, `acc_v_o = resp_v_o = busy_o = 0`, `done_count_o = 0`; release → no activity.
- WRITE then READ, with a behavioural accelerator model:
  - Push WRITE (D=0, data `0x01010101`), then READ (A=0).
  - Expect `acc_v_o` 2 cycles after the first accept, and in-order issue.
  - Expect `resp_data_o = 0x01010101`, `done_count_o = 2`.
- FIFO full: hold `acc_ready_i = 0` and push 5 WRITEs (D=0..4).
  - `cmd_ready_o` drops after the 4th accept and the 5th is not captured.
  - Release → accelerator sees D=0,1,2,3 in order, and `cmd_ready_o` returns high after the first pop.
- Response backpressure: READ with `resp_ready_i = 0` for 6 cycles.
  - `resp_v_o` stays high and `resp_data_o` stays constant.
  - A queued WRITE is not issued until `resp_ready_i` goes high.
- Matrix sequence: 8 WRITEs (D=0..7, matrix data), MMUL (D=8, A=0, B=4), 4 READs (A=8..11).
  - Responses are `0x08080706`, `0x0C0C0C08`, `0x0C0C090A`, `0x0E0B0A08`.
  - `done_count_o = 13`; MMUL gives no response.
- Reset mid-WAIT: drop `reset_n_i` while waiting on an MMUL with 2 commands queued → outputs are at reset values immediately, and after release the FIFO is empty and nothing is issued.
